// File: rtl/simple_bidir_ram_be_clr.sv
// Two-port byte-enable RAM, write-first with cross-port forwarding and zero-fill FSM.
// Define SIMPLE_BIDIR_RAM_OUTREG_EN to add an output register (read latency 2).
module simple_bidir_ram_be_clr #(
    parameter int width   = 32,
    parameter int widthad = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [widthad-1:0]   address_a,
    input  logic                 wren_a,
    input  logic [width/8-1:0]   byteena_a,
    input  logic [width-1:0]     data_a,
    output logic [width-1:0]     q_a,
    input  logic [widthad-1:0]   address_b,
    input  logic                 wren_b,
    input  logic [width/8-1:0]   byteena_b,
    input  logic [width-1:0]     data_b,
    output logic [width-1:0]     q_b,
    input  logic                 clear,
    output logic                 busy
);

    localparam int nbytes = width / 8;
    localparam int depth  = 2 ** widthad;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [widthad-1:0]   cnt_q, cnt_d;
    logic [width-1:0]     mem [depth];
    logic                 wr_a, wr_b;
    logic [width-1:0]     fin_a, fin_b;
    logic [width-1:0]     rd_a_q, rd_b_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            CLEAR: begin
                cnt_d = cnt_q + widthad'(1);
                if (cnt_q == '1) state_d = IDLE;
            end
            IDLE: begin
                if (clear) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_comb begin
        busy = (state_q == CLEAR);
        wr_a = wren_a & ~busy;
        wr_b = wren_b & ~busy;
    end

    // Final word seen at each port's address: A's bytes first, B wins on overlap.
    always_comb begin
        fin_a = mem[address_a];
        fin_b = mem[address_b];
        for (int i = 0; i < nbytes; i++) begin
            if (wr_a && byteena_a[i])
                fin_a[8*i +: 8] = data_a[8*i +: 8];
            if (wr_b && byteena_b[i] && (address_b == address_a))
                fin_a[8*i +: 8] = data_b[8*i +: 8];
            if (wr_a && byteena_a[i] && (address_a == address_b))
                fin_b[8*i +: 8] = data_a[8*i +: 8];
            if (wr_b && byteena_b[i])
                fin_b[8*i +: 8] = data_b[8*i +: 8];
        end
    end

    // Array has no reset; the fill is held off while rst_n is low.
    always_ff @(posedge clk) begin
        if (busy) begin
            if (rst_n) mem[cnt_q] <= '0;
        end else begin
            if (wr_a && (|byteena_a)) mem[address_a] <= fin_a;
            if (wr_b && (|byteena_b)) mem[address_b] <= fin_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_a_q <= '0;
            rd_b_q <= '0;
        end else if (busy) begin
            rd_a_q <= '0;
            rd_b_q <= '0;
        end else begin
            rd_a_q <= fin_a;
            rd_b_q <= fin_b;
        end
    end

`ifdef SIMPLE_BIDIR_RAM_OUTREG_EN
    logic [width-1:0] out_a_q, out_b_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_a_q <= '0;
            out_b_q <= '0;
        end else if (busy) begin
            out_a_q <= '0;
            out_b_q <= '0;
        end else begin
            out_a_q <= rd_a_q;
            out_b_q <= rd_b_q;
        end
    end

    assign q_a = out_a_q;
    assign q_b = out_b_q;
`else
    assign q_a = rd_a_q;
    assign q_b = rd_b_q;
`endif

endmodule

// File: doc/simple_bidir_ram_be_clr.md
Name: simple_bidir_ram_be_clr

Overview:
Single-clock, two-port RAM with per-byte write enables on both ports. Write-first and cross-port forwarding make every read return the final stored value for that cycle. A built-in zero-fill state machine runs after reset or on request. Drop-in successor for small shared tables (cache tags, TLB, VGA/palette stores) that need deterministic contents and two writers.

Parameters:
width, 32, data word width in bits; must be a multiple of 8.
widthad, 8, address width; depth = 2**widthad words.
(derived) nbytes = width/8, byte-enable width.

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
address_a  in  widthad  port A word address
wren_a  in  1  port A write strobe
byteena_a  in  nbytes  port A byte enables; bit i covers data[8i+7:8i]
data_a  in  width  port A write data
q_a  out  width  port A read data
address_b  in  widthad  port B word address
wren_b  in  1  port B write strobe
byteena_b  in  nbytes  port B byte enables
data_b  in  width  port B write data
q_b  out  width  port B read data
clear  in  1  single-cycle request to zero-fill the whole array
busy  out  1  high while zero-fill runs; port accesses ignored

Behaviour:
- Reset (rst_n low, async):
  - q_a = 0, q_b = 0, busy = 1.
  - Clear FSM forced to CLEAR; fill counter = 0.
  - Array contents are not touched by rst_n itself.
- FSM states:
  - CLEAR: each cycle writes 0 to mem[counter] and increments counter.
  - After writing address 2**widthad-1, go to IDLE next cycle; busy drops in that same edge.
  - Fill takes exactly 2**widthad cycles after rst_n deasserts.
  - IDLE: clear = 1 enters CLEAR next cycle with counter = 0; busy = 1 from that edge.
- clear while in CLEAR: ignored; no restart and no extension.
- rst_n asserted mid-fill: counter returns to 0 and the fill restarts from address 0 after release.
- While busy:
  - wren_a/wren_b are dropped and reads are not performed.
  - q_a and q_b are driven 0.
- IDLE read: q_x <= value at address_x, latency 1 cycle.
- Write effect: wren_x = 1 updates only the bytes whose byteena_x bit is set. byteena_x = 0 is a no-op.
- Write-first, same port: a read at the written address returns the merged new word, i.e. enabled bytes from data_x and other bytes from the old contents.
- Cross-port forwarding: port B reading the address port A writes in the same cycle returns A's merged word, and vice versa.
- Both ports write the same address in the same cycle:
  - Bytes enabled on both ports take data_b (port B wins).
  - Bytes enabled on one port only take that port's data.
  - Both q outputs return the final merged word.
- Both ports write different addresses: independent, no interaction.
- Address wrap: none; every address is a valid word.

Optional Feature:
SIMPLE_BIDIR_RAM_OUTREG_EN
- Defined:
  - Adds an output pipeline register on q_a and q_b; read latency becomes 2 cycles.
  - Forwarding and byte-merge results are identical, just delayed one cycle.
  - Output registers reset to 0 and present 0 while busy or on the cycle after busy.
- Undefined: latency 1 as specified above.

Test Plan:
- Reset release, width=32, widthad=4 -> busy high for exactly 16 cycles; afterwards reading every address returns 0x00000000.
- Write A addr 3, data 0xAABBCCDD, byteena 4'b1111; next cycle write A addr 3, data 0x11223344, byteena 4'b0101 -> read addr 3 returns 0xAA22CC44, 1 cycle after address is presented.
- Same cycle: A writes addr 5 = 0x11111111 with byteena 4'b0011, and B reads addr 5 (old value 0) -> q_b = 0x00001111 next cycle.
- Same cycle: A writes addr 7 = 0xAAAAAAAA with byteena 4'b1110, and B writes addr 7 = 0xBBBBBBBB with byteena 4'b0111 -> q_a = q_b = 0xAABBBBBB; later read of addr 7 = 0xAABBBBBB.
- Pulse clear after filling memory, then assert wren_a to addr 2 at cycle 3 of the fill, and pulse clear again at cycle 5 -> busy high exactly 16 cycles; write dropped; q_a = q_b = 0 while busy; addr 2 reads 0 afterwards.
- Assert rst_n low at fill cycle 8, release -> fill restarts; busy stays high a further 16 cycles; with SIMPLE_BIDIR_RAM_OUTREG_EN defined, repeat the byte-merge case and check the same data appears at latency 2.
